lf_motor_controller: RTL

LF_MOTOR_CONTROLLER -- requirements
Module: lf_motor_controller

---
 rtl/lf_motor_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/lf_motor_controller.sv
// Line-following motor controller: frame-driven steering FSM feeding a shadow-loaded 8-bit PWM.
// Optional build macro LF_STOP_DEBOUNCE_EN requires two consecutive stop events to halt.
module lf_motor_controller #(
    parameter int unsigned H_CENTRE    = 160,
    parameter int unsigned BASE_DUTY   = 160,
    parameter int unsigned KP_SHIFT    = 1,
    parameter int unsigned SEARCH_DUTY = 128,
    parameter int unsigned LOST_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run_enable,
    input  logic       frame_done,
    input  logic [9:0] h_centroid,
    input  logic       stop_detect,
    output logic       pwm_left,
    output logic       pwm_right,
    output logic [7:0] duty_left,
    output logic [7:0] duty_right,
    output logic [1:0] state,
    output logic       line_lost
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FOLLOW = 2'd1,
        SEARCH = 2'd2,
        STOP   = 2'd3
    } state_e;

    localparam int                 LW         = $clog2(LOST_FRAMES + 1);
    localparam logic [LW-1:0]      LOST_LAST  = LW'(LOST_FRAMES - 1);
    localparam logic signed [10:0] H_CENTRE_S = 11'(H_CENTRE);
    localparam logic signed [12:0] BASE_S     = 13'(BASE_DUTY);
    localparam logic [7:0]         SEARCH_D   = 8'(SEARCH_DUTY);

    state_e            state_q, state_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        duty_left_q, duty_left_d;
    logic [7:0]        duty_right_q, duty_right_d;
    logic [7:0]        tgt_left_q, tgt_left_d;
    logic [7:0]        tgt_right_q, tgt_right_d;
    logic [LW-1:0]     lost_q, lost_d;
    logic              last_dir_q, last_dir_d;

    logic              frame_event;
    logic              accept;
    logic              centroid_nz;
    logic              stop_hit;
    logic              lost_hit;
    logic signed [10:0] error;
    logic signed [12:0] error_x;
    logic signed [12:0] corr;
    logic signed [12:0] sum_left;
    logic signed [12:0] diff_right;
    logic [7:0]        calc_left;
    logic [7:0]        calc_right;

    function automatic logic [7:0] sat8(input logic signed [12:0] v);
        if (v[12]) return 8'd0;
        if (v > 13'sd255) return 8'd255;
        return v[7:0];
    endfunction

    // Events only count while actively driving; a falling run_enable swallows a coincident event.
    always_comb begin
        frame_done_d = frame_done;
        frame_event  = frame_done && !frame_done_q;
        accept       = frame_event && run_enable && (state_q == FOLLOW || state_q == SEARCH);
        centroid_nz  = (h_centroid != 10'd0);
        lost_hit     = accept && !centroid_nz && (state_q == FOLLOW) && (lost_q >= LOST_LAST);
    end

`ifdef LF_STOP_DEBOUNCE_EN
    logic stop_cnt_q, stop_cnt_d;

    assign stop_hit = accept && stop_detect && stop_cnt_q;

    always_comb begin
        stop_cnt_d = stop_cnt_q;
        if (state_d != FOLLOW && state_d != SEARCH) begin
            stop_cnt_d = 1'b0;
        end else if (accept) begin
            stop_cnt_d = stop_detect;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stop_cnt_q <= 1'b0;
        end else begin
            stop_cnt_q <= stop_cnt_d;
        end
    end
`else
    assign stop_hit = accept && stop_detect;
`endif

    always_comb begin
        error      = $signed({1'b0, h_centroid}) - H_CENTRE_S;
        error_x    = {{2{error[10]}}, error};
        corr       = error_x >>> KP_SHIFT;
        sum_left   = BASE_S + corr;
        diff_right = BASE_S - corr;
        calc_left  = sat8(sum_left);
        calc_right = sat8(diff_right);
    end

    // NOTE: every combinational output is given a default before any branch so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (!run_enable) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_d = FOLLOW;
                FOLLOW: begin
                    if (stop_hit)      state_d = STOP;
                    else if (lost_hit) state_d = SEARCH;
                end
                SEARCH: begin
                    if (stop_hit)                    state_d = STOP;
                    else if (accept && centroid_nz)  state_d = FOLLOW;
                end
                STOP:    state_d = STOP;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d        = cnt_q + 8'd1;
        lost_d       = lost_q;
        last_dir_d   = last_dir_q;
        tgt_left_d   = tgt_left_q;
        tgt_right_d  = tgt_right_q;
        duty_left_d  = duty_left_q;
        duty_right_d = duty_right_q;

        if (accept && centroid_nz) begin
            last_dir_d = !error[10] && (error != 11'sd0);
        end

        if (state_d != state_q || (accept && centroid_nz)) begin
            lost_d = '0;
        end else if (accept && state_q == FOLLOW) begin
            lost_d = lost_q + LW'(1);
        end

        case (state_d)
            FOLLOW: begin
                if (accept && centroid_nz) begin
                    tgt_left_d  = calc_left;
                    tgt_right_d = calc_right;
                end
            end
            SEARCH: begin
                tgt_left_d  = last_dir_d ? SEARCH_D : 8'd0;
                tgt_right_d = last_dir_d ? 8'd0 : SEARCH_D;
            end
            default: begin
                tgt_left_d  = 8'd0;
                tgt_right_d = 8'd0;
            end
        endcase

        // Halting drops the drive immediately; otherwise duties change only at the period wrap.
        if (state_d == IDLE || state_d == STOP) begin
            duty_left_d  = 8'd0;
            duty_right_d = 8'd0;
        end else if (cnt_q == 8'hFF) begin
            duty_left_d  = tgt_left_q;
            duty_right_d = tgt_right_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            // NOTE: frame_done history resets high so a level already asserted through reset is not an edge.
            frame_done_q <= 1'b1;
            cnt_q        <= 8'd0;
            duty_left_q  <= 8'd0;
            duty_right_q <= 8'd0;
            tgt_left_q   <= 8'd0;
            tgt_right_q  <= 8'd0;
            lost_q       <= '0;
            last_dir_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= frame_done_d;
            cnt_q        <= cnt_d;
            duty_left_q  <= duty_left_d;
            duty_right_q <= duty_right_d;
            tgt_left_q   <= tgt_left_d;
            tgt_right_q  <= tgt_right_d;
            lost_q       <= lost_d;
            last_dir_q   <= last_dir_d;
        end
    end

    assign pwm_left   = (cnt_q < duty_left_q);
    assign pwm_right  = (cnt_q < duty_right_q);
    assign duty_left  = duty_left_q;
    assign duty_right = duty_right_q;
    assign state      = state_q;
    assign line_lost  = (state_q == SEARCH);

endmodule
